result_page_sequencer: RTL and testbench
========================================

# result_page_sequencer

Controller that collects the eight 8-bit convolution results (c9 and c4 2x2 outputs, in order c9_11, c9_12, c9_21, c9_22, c4_11, c4_12, c4_21, c4_22) from the conv engine over a valid/ready handshake. It buffers them and then sequences them page by page to the 7-segment display path (BCD conversion, decoders, digit scan). Page advance is automatic after a programmable dwell, or manual via a step pulse.

## Interface
Parameters:
- DWELL_CYCLES, 500, clk cycles each page is shown; legal range >= 2.
- DATA_W, 8, result width.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle pulse; begins a new capture frame.
- res_valid  input  1  conv engine result valid.
- res_data  input  DATA_W  conv engine result.
- res_ready  output  1  sequencer accepts a result this cycle.
- step  input  1  single-cycle pulse, already synchronized and debounced; manual page advance.
- hold  input  1  level; freezes automatic advance.
- disp_value  output  DATA_W  value of the current page.
- disp_page  output  3  current page index, 0..7.
- disp_valid  output  1  high while a page is being shown.
- busy  output  1  high in CAPTURE.
- frame_done  output  1  one-cycle pulse when page 7's display period ends.

## Operation
- Internal storage: buf[0..7] of DATA_W, plus wr_ptr (3 bits), page (3 bits) and dwell counter (clog2(DWELL_CYCLES) bits).
- States and transitions:
  - IDLE → CAPTURE on start.
  - CAPTURE → SHOW when the 8th result is accepted.
  - SHOW → SHOW (page advance), or → LAST when page 7 ends (SEQ_WRAP_EN undefined only).
  - Any state → CAPTURE on start.
- IDLE:
  - res_ready=0, disp_valid=0, busy=0.
  - start → CAPTURE with wr_ptr=0.
- CAPTURE:
  - res_ready=1, busy=1, disp_valid=0.
  - Handshake = res_valid & res_ready; each handshake writes buf[wr_ptr]<=res_data and increments wr_ptr.
  - Cycles with res_valid=0 are ignored.
  - Handshake with wr_ptr==7 → SHOW with page=0, dwell=0, disp_value<=buf[0].
- SHOW:
  - disp_valid=1; dwell increments each cycle unless hold=1.
  - Advance occurs when dwell==DWELL_CYCLES-1 (and hold=0), or when step=1.
  - Step and expiry in the same cycle produce exactly one advance.
  - Advance: page<=page+1, dwell<=0, disp_value<=buf[page+1].
  - step while hold=1 still advances; hold remains in effect on the new page.
- End of page 7 (advance from page 7): frame_done pulses for 1 cycle; the next action depends on SEQ_WRAP_EN (see Configuration).
- LAST (SEQ_WRAP_EN undefined only):
  - page=7, disp_valid=1, disp_value=buf[7].
  - Counter is stopped; step and hold are ignored.
- start in any state:
  - → CAPTURE, wr_ptr=0, disp_valid=0, page=0.
  - A partial frame is discarded; buf contents are not cleared but are overwritten.
- res_ready is 0 in every state except CAPTURE.

## Timing
- Reset values (resetn low, asynchronous):
  - state=IDLE, wr_ptr=0, page=0, dwell=0, buf=0.
  - Outputs: res_ready=0, disp_value=0, disp_page=0, disp_valid=0, busy=0, frame_done=0.
- All outputs are registered except res_ready and busy, which decode state directly.
- start sampled at edge N: res_ready=1 from cycle N+1.
- 8th handshake at edge N: res_ready=0 and disp_valid=1 with disp_page=0 from cycle N+1.
- disp_page and disp_value always change on the same edge.
- With hold=0 and no step, each page is shown for exactly DWELL_CYCLES cycles.
- frame_done is asserted during the first cycle after page 7 ends.
- step latency: the page changes on the edge that samples step.
- Deassertion of resetn is synchronized externally; the block needs no internal reset synchronizer.

## Configuration
- SEQ_WRAP_EN defined: advance from page 7 returns to page 0 with dwell=0 and stays in SHOW. Display cycles continuously; frame_done pulses once per lap.
- SEQ_WRAP_EN undefined: advance from page 7 enters LAST and holds page 7 until start or reset. frame_done pulses once.

## Test plan
1. Assert resetn=0 mid-SHOW → all outputs go to 0 immediately without a clock edge, state returns to IDLE, res_ready=0.
2. Back-to-back capture and auto-advance: DWELL_CYCLES=4, start, then 8 back-to-back results 10,20,…,80 → res_ready falls after the 8th, disp_valid=1 next cycle, pages 0..7 show 10..80 for exactly 4 cycles each.
3. Handshake gaps: res_valid toggled 1,0,1,0 with values 1..8 → only valid cycles are stored; pages show 1..8 in order.
4. Hold and step: hold=1 on page 2 for 20 cycles → page stays 2. step pulse → page 3 on the next edge. step coincident with dwell expiry → advances only one page.
5. End of frame: after page 7 expires, with SEQ_WRAP_EN defined → page 0 with value 10 and frame_done=1 for one cycle. With SEQ_WRAP_EN undefined → page 7 is held indefinitely, frame_done pulses once, and step is ignored.
6. Restart mid-capture: start after 3 results, then a second start, then results 101..108 → pages show 101..108 and the earlier partial data never appears.

Source files
------------

// File: rtl/result_page_sequencer_if.sv
// Result handshake between the conv engine (master) and result_page_sequencer (slave).
interface result_page_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;

  modport master (output res_valid, res_data, input res_ready);
  modport slave  (input res_valid, res_data, output res_ready);
endinterface

// File: rtl/result_page_sequencer.sv
// Captures eight conv results, then pages them to the 7-segment path with dwell/step/hold control.
// Optional macro SEQ_WRAP_EN: page 7 wraps to page 0 instead of parking in LAST.
module result_page_sequencer #(
  parameter int DWELL_CYCLES = 500,
  parameter int DATA_W       = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  result_page_sequencer_if.slave  res,
  input  logic                    step,
  input  logic                    hold,
  output logic [DATA_W-1:0]       disp_value,
  output logic [2:0]              disp_page,
  output logic                    disp_valid,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int            CW         = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SHOW, LAST} state_t;

  state_t                  state;
  logic [7:0][DATA_W-1:0]  buf_mem;
  logic [2:0]              wr_ptr;
  logic [2:0]              page;
  logic [CW-1:0]           dwell;
  logic                    hs;
  logic                    adv;

  assign res.res_ready = (state == CAPTURE);
  assign busy          = (state == CAPTURE);
  assign disp_page     = page;

  assign hs  = res.res_valid & res.res_ready;
  // step always advances; expiry only when not held. Both together are one advance.
  assign adv = step | (~hold & (dwell == DWELL_LAST));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      buf_mem    <= '0;
      wr_ptr     <= '0;
      page       <= '0;
      dwell      <= '0;
      disp_value <= '0;
      disp_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start) begin
        state      <= CAPTURE;
        wr_ptr     <= '0;
        page       <= '0;
        dwell      <= '0;
        disp_valid <= 1'b0;
        disp_value <= '0;
      end else begin
        case (state)
          IDLE: ;
          CAPTURE: begin
            if (hs) begin
              buf_mem[wr_ptr] <= res.res_data;
              wr_ptr          <= wr_ptr + 3'd1;
              if (wr_ptr == 3'd7) begin
                state      <= SHOW;
                page       <= '0;
                dwell      <= '0;
                disp_valid <= 1'b1;
                disp_value <= buf_mem[0];
              end
            end
          end
          SHOW: begin
            if (adv) begin
              dwell <= '0;
              if (page == 3'd7) begin
                frame_done <= 1'b1;
`ifdef SEQ_WRAP_EN
                page       <= '0;
                disp_value <= buf_mem[0];
`else
                state      <= LAST;
`endif
              end else begin
                page       <= page + 3'd1;
                disp_value <= buf_mem[page + 3'd1];
              end
            end else if (!hold) begin
              dwell <= dwell + CW'(1);
            end
          end
          // Page 7 stays up with the counter frozen until start or reset.
          LAST: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_result_page_sequencer.sv
// Directed bench for result_page_sequencer with DWELL_CYCLES=4; follows SEQ_WRAP_EN if defined.
module tb_result_page_sequencer;
  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] disp_value;
  logic [2:0] disp_page;
  logic       disp_valid, busy, frame_done;
  int         total = 0;
  int         bad = 0;
  int         fd;

  result_page_sequencer_if #(.DATA_W(8)) rif ();

  result_page_sequencer #(.DWELL_CYCLES(DW), .DATA_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .res        (rif),
    .step       (step),
    .hold       (hold),
    .disp_value (disp_value),
    .disp_page  (disp_page),
    .disp_valid (disp_valid),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic capture(input int base, input int scale);
    for (int i = 0; i < 8; i++) begin
      rif.res_valid = 1'b1;
      rif.res_data  = 8'(base + scale * (i + 1));
      tick();
    end
    rif.res_valid = 1'b0;
    rif.res_data  = 8'hEE;
  endtask

  // Entered on the first cycle of page 0; leaves on the first cycle after page 7.
  task automatic check_frame(input int base, input int scale);
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < DW; k++) begin
        chk("page", 32'(disp_page), 32'(p));
        chk("value", 32'(disp_value), 32'(base + scale * (p + 1)));
        tick();
      end
    end
  endtask

  initial begin
    rif.res_valid = 1'b0;
    rif.res_data  = 8'h00;

    // Reset state
    tick();
    chk("rst_ready", 32'(rif.res_ready), 0);
    chk("rst_value", 32'(disp_value), 0);
    chk("rst_page", 32'(disp_page), 0);
    chk("rst_dvalid", 32'(disp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fdone", 32'(frame_done), 0);
    resetn = 1'b1;
    tick();
    chk("idle_ready", 32'(rif.res_ready), 0);

    // Back-to-back capture and auto-advance
    pulse_start();
    chk("cap_ready", 32'(rif.res_ready), 1);
    chk("cap_busy", 32'(busy), 1);
    chk("cap_dvalid", 32'(disp_valid), 0);
    capture(0, 10);
    chk("show_ready", 32'(rif.res_ready), 0);
    chk("show_busy", 32'(busy), 0);
    chk("show_dvalid", 32'(disp_valid), 1);
    check_frame(0, 10);

    // End of frame
    chk("eof_fdone", 32'(frame_done), 1);
    chk("eof_dvalid", 32'(disp_valid), 1);
`ifdef SEQ_WRAP_EN
    chk("wrap_page", 32'(disp_page), 0);
    chk("wrap_value", 32'(disp_value), 10);
    fd = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      fd += int'(frame_done);
    end
    chk("wrap_fdone_quiet", 32'(fd), 0);
    tick();
    chk("wrap_fdone_lap2", 32'(frame_done), 1);
`else
    chk("last_page", 32'(disp_page), 7);
    chk("last_value", 32'(disp_value), 80);
    tick();
    chk("last_fdone_off", 32'(frame_done), 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("last_step_page", 32'(disp_page), 7);
    fd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      fd += int'(frame_done);
    end
    chk("last_fdone_once", 32'(fd), 0);
    chk("last_hold_page", 32'(disp_page), 7);
    chk("last_hold_value", 32'(disp_value), 80);
`endif

    // Handshake gaps: only valid cycles are stored
    pulse_start();
    for (int j = 0; j < 8; j++) begin
      rif.res_valid = 1'b1;
      rif.res_data  = 8'(j + 1);
      tick();
      if (j < 7) begin
        rif.res_valid = 1'b0;
        rif.res_data  = 8'hEE;
        tick();
      end
    end
    rif.res_valid = 1'b0;
    check_frame(0, 1);

    // Hold and step
    pulse_start();
    capture(0, 10);
    repeat (8) tick();
    chk("hs_page2", 32'(disp_page), 2);
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_page", 32'(disp_page), 2);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_page", 32'(disp_page), 3);
    chk("step_value", 32'(disp_value), 40);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_new_page", 32'(disp_page), 3);
    end
    hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("resume_page3", 32'(disp_page), 3);
      tick();
    end
    chk("resume_page4", 32'(disp_page), 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("page4_dwell", 32'(disp_page), 4);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("coinc_page", 32'(disp_page), 5);
    chk("coinc_value", 32'(disp_value), 60);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("coinc_dwell", 32'(disp_page), 5);
    end
    tick();
    chk("after_coinc", 32'(disp_page), 6);

    // Restart mid-capture
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      rif.res_valid = 1'b1;
      rif.res_data  = 8'(201 + i);
      tick();
    end
    rif.res_valid = 1'b0;
    tick();
    pulse_start();
    chk("restart_busy", 32'(busy), 1);
    chk("restart_dvalid", 32'(disp_valid), 0);
    capture(100, 1);
    check_frame(100, 1);

    // Asynchronous reset mid-SHOW
    pulse_start();
    capture(0, 10);
    repeat (6) tick();
    chk("pre_rst_page", 32'(disp_page), 1);
    chk("pre_rst_dvalid", 32'(disp_valid), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_value", 32'(disp_value), 0);
    chk("arst_page", 32'(disp_page), 0);
    chk("arst_dvalid", 32'(disp_valid), 0);
    chk("arst_ready", 32'(rif.res_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_fdone", 32'(frame_done), 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("post_rst_idle", 32'(rif.res_ready), 0);
    chk("post_rst_dvalid", 32'(disp_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
